// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcodes and instruction field positions for the ALU and its operand stage
package alu_pkg;
  localparam int DW = 16;
  localparam int NREG = 8;
  localparam int AW = $clog2(NREG);
  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SHIFT  = 2'b01,
    OP_ROTATE = 2'b10,
    OP_ZERO   = 2'b11
  } alu_op_e;
  localparam int OP_LSB = 14;
  localparam int RD_LSB = 11;
  localparam int RS1_LSB = 8;
  localparam int IMM_FLAG = 7;
  localparam int RS2_LSB = 4;
  localparam int IMM_W = 7;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 8x16 register file, two combinational reads, one synchronous write, r0 fixed at zero
module alu_regfile
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr1,
  input  logic [AW-1:0] i_raddr2,
  output logic [DW-1:0] o_rdata1,
  output logic [DW-1:0] o_rdata2
);
  logic [DW-1:0] r_mem [NREG];
  always_ff @(posedge clk)
    if (!rst_n)
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    else if (i_we && i_waddr != '0)
      r_mem[i_waddr] <= i_wdata;
  assign o_rdata1 = i_raddr1 == '0 ? '0 : r_mem[i_raddr1];
  assign o_rdata2 = i_raddr2 == '0 ? '0 : r_mem[i_raddr2];
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decodes, reads and forwards operands, tracks pending writebacks, issues to the ALU
module alu_operand_stage
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] data1,
  output logic [DW-1:0] data2,
  output logic [1:0]    ALUop,
  output logic [AW-1:0] out_rd,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data
);
  alu_op_e         w_op, r_op;
  logic [AW-1:0]   w_rd, w_rs1, w_rs2;
  logic            w_use_imm, w_hit1, w_hit2, w_stall, w_acc;
  logic [DW-1:0]   w_rf1, w_rf2, w_d1, w_d2;
  logic [NREG-1:0] r_pending, w_set, w_clr;

  assign w_op      = alu_op_e'(instr[OP_LSB +: 2]);
  assign w_rd      = instr[RD_LSB +: AW];
  assign w_rs1     = instr[RS1_LSB +: AW];
  assign w_rs2     = instr[RS2_LSB +: AW];
  assign w_use_imm = instr[IMM_FLAG];
  assign w_hit1    = wb_en && wb_addr == w_rs1;
  assign w_hit2    = wb_en && wb_addr == w_rs2;
  assign w_d1      = w_rs1 == '0 ? '0 : w_hit1 ? wb_data : w_rf1;
  assign w_d2      = w_use_imm ? DW'(instr[IMM_W-1:0]) : w_rs2 == '0 ? '0 : w_hit2 ? wb_data : w_rf2;
  assign w_stall   = (r_pending[w_rs1] && !w_hit1) || (!w_use_imm && r_pending[w_rs2] && !w_hit2);
  assign in_ready  = !w_stall && (!out_valid || out_ready);
  assign w_acc     = in_valid && in_ready;
  assign w_clr     = wb_en ? NREG'(1) << wb_addr : '0;
  assign w_set     = w_acc && w_rd != '0 ? NREG'(1) << w_rd : '0;
  assign ALUop     = r_op;

  alu_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (wb_en),
    .i_waddr  (wb_addr),
    .i_wdata  (wb_data),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rf1),
    .o_rdata2 (w_rf2)
  );

  always_ff @(posedge clk)
    if (!rst_n) begin
      r_pending <= '0;
      out_valid <= 1'b0;
      data1     <= '0;
      data2     <= '0;
      r_op      <= OP_ADD;
      out_rd    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_acc) begin
        out_valid <= 1'b1;
        data1     <= w_d1;
        data2     <= w_d2;
        r_op      <= w_op;
        out_rd    <= w_rd;
      end else if (out_ready)
        out_valid <= 1'b0;
    end
endmodule
